// File: rtl/countdown_ctrl.sv
// Countdown timer controller: BCD preset entry, one-second tick countdown,
// pause/resume and a timed alarm with a single-cycle done pulse.
module countdown_ctrl #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1000,
    parameter int BEEP_SEC = 3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  key_start,
    input  logic                  key_clr,
    input  logic [DIGITS-1:0]     key_inc,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            state,
    output logic                  beep,
    output logic                  done
);

    localparam int TICK_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BEEP_CYC = BEEP_SEC * TICK_DIV;
    localparam int BEEP_W   = $clog2(BEEP_CYC);
    localparam int BCD_W    = 4 * DIGITS;

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_ALARM = 3'd4;

    localparam logic [BCD_W-1:0]  BCD_ZERO  = {BCD_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYC - 1);

    logic [2:0]        state_r, state_s;
    logic [BCD_W-1:0]  bcd_r, bcd_s;
    logic [BCD_W-1:0]  preset_r, preset_s;
    logic [TICK_W-1:0] tick_r, tick_s;
    logic [BEEP_W-1:0] beep_cnt_r, beep_cnt_s;
    logic              beep_r, beep_s;
    logic              done_r, done_s;
    logic [BCD_W-1:0]  dec_s;

    // Single BCD digit increment, wrapping 9 -> 0.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd9) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Whole-value BCD decrement with borrow rippling from the units digit up.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!borrow) begin
                r[4*i +: 4] = v[4*i +: 4];
            end else if (v[4*i +: 4] == 4'd0) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    // Next-state and datapath update, priority en=0 > clr > start > inc.
    always_comb begin
        state_s    = state_r;
        bcd_s      = bcd_r;
        preset_s   = preset_r;
        tick_s     = tick_r;
        beep_cnt_s = beep_cnt_r;
        beep_s     = beep_r;
        done_s     = 1'b0;
        dec_s      = bcd_dec(bcd_r);

        if (!en) begin
            state_s    = ST_OFF;
            bcd_s      = BCD_ZERO;
            preset_s   = BCD_ZERO;
            tick_s     = {TICK_W{1'b0}};
            beep_cnt_s = {BEEP_W{1'b0}};
            beep_s     = 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_s  = ST_IDLE;
                    bcd_s    = BCD_ZERO;
                    preset_s = BCD_ZERO;
                    tick_s   = {TICK_W{1'b0}};
                    beep_s   = 1'b0;
                end
                ST_IDLE: begin
                    if (key_clr) begin
                        bcd_s    = BCD_ZERO;
                        preset_s = BCD_ZERO;
                    end else if (key_start) begin
                        if (bcd_r != BCD_ZERO) begin
                            preset_s = bcd_r;
                            tick_s   = {TICK_W{1'b0}};
                            state_s  = ST_RUN;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        // Digits roll independently: no carry between them.
                        for (int i = 0; i < DIGITS; i++) begin
                            if (key_inc[i]) begin
                                bcd_s[4*i +: 4] = digit_inc(bcd_r[4*i +: 4]);
                            end else begin
                                bcd_s[4*i +: 4] = bcd_r[4*i +: 4];
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (key_clr) begin
                        bcd_s   = preset_r;
                        state_s = ST_IDLE;
                    end else if (key_start) begin
                        state_s = ST_PAUSE;
                    end else if (tick_r == TICK_LAST) begin
                        tick_s = {TICK_W{1'b0}};
                        bcd_s  = dec_s;
                        if (dec_s == BCD_ZERO) begin
                            state_s    = ST_ALARM;
                            done_s     = 1'b1;
                            beep_s     = 1'b1;
                            beep_cnt_s = {BEEP_W{1'b0}};
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        tick_s = tick_r + TICK_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (key_clr) begin
                        bcd_s   = preset_r;
                        state_s = ST_IDLE;
                    end else if (key_start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_ALARM: begin
                    if (key_clr || key_start || (beep_cnt_r == BEEP_LAST)) begin
                        bcd_s      = preset_r;
                        beep_s     = 1'b0;
                        beep_cnt_s = {BEEP_W{1'b0}};
                        state_s    = ST_IDLE;
                    end else begin
                        beep_cnt_s = beep_cnt_r + BEEP_W'(1);
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    bcd_s      = BCD_ZERO;
                    tick_s     = {TICK_W{1'b0}};
                    beep_cnt_s = {BEEP_W{1'b0}};
                    beep_s     = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_OFF;
            bcd_r      <= BCD_ZERO;
            preset_r   <= BCD_ZERO;
            tick_r     <= {TICK_W{1'b0}};
            beep_cnt_r <= {BEEP_W{1'b0}};
            beep_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bcd_r      <= bcd_s;
            preset_r   <= preset_s;
            tick_r     <= tick_s;
            beep_cnt_r <= beep_cnt_s;
            beep_r     <= beep_s;
            done_r     <= done_s;
        end
    end

    assign bcd   = bcd_r;
    assign state = state_r;
    assign beep  = beep_r;
    assign done  = done_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed table-driven bench for countdown_ctrl (DIGITS=2, TICK_DIV=4, BEEP_SEC=2).
module tb_countdown_ctrl;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_ALARM = 3'd4;

    logic       clk;
    logic       nrst;
    logic       en;
    logic       key_start;
    logic       key_clr;
    logic [1:0] key_inc;
    logic [7:0] bcd;
    logic [2:0] state;
    logic       beep;
    logic       done;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       en;
        logic       start;
        logic       clr;
        logic [1:0] inc;
        int         reps;
        logic [2:0] exp_state;
        logic [7:0] exp_bcd;
        logic       exp_beep;
        logic       exp_done;
    } vec_t;

    vec_t vq[$];

    countdown_ctrl #(.DIGITS(2), .TICK_DIV(4), .BEEP_SEC(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .key_start (key_start),
        .key_clr   (key_clr),
        .key_inc   (key_inc),
        .bcd       (bcd),
        .state     (state),
        .beep      (beep),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic e, input logic s, input logic c, input logic [1:0] i,
                       input int reps, input logic [2:0] st, input logic [7:0] b,
                       input logic bp, input logic dn);
        vec_t v;
        v.en = e; v.start = s; v.clr = c; v.inc = i; v.reps = reps;
        v.exp_state = st; v.exp_bcd = b; v.exp_beep = bp; v.exp_done = dn;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [7:0] b,
                         input logic bp, input logic dn);
        tests_run++;
        if (state !== st || bcd !== b || beep !== bp || done !== dn) begin
            tests_failed++;
            $display("FAIL %s: got state=%0d bcd=%h beep=%b done=%b, expected state=%0d bcd=%h beep=%b done=%b",
                     name, state, bcd, beep, done, st, b, bp, dn);
        end
    endtask

    task automatic drive(input logic e, input logic s, input logic c, input logic [1:0] i);
        en = e; key_start = s; key_clr = c; key_inc = i;
        @(posedge clk);
        #1;
        key_start = 1'b0; key_clr = 1'b0; key_inc = 2'b00;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        nrst = 1'b0; en = 1'b0; key_start = 1'b0; key_clr = 1'b0; key_inc = 2'b00;

        // Key entry and digit wrap without carry
        add(1,0,0,2'b00,1,S_IDLE,8'h00,0,0);
        add(1,0,0,2'b01,1,S_IDLE,8'h01,0,0);
        add(1,0,0,2'b01,1,S_IDLE,8'h02,0,0);
        add(1,0,0,2'b01,1,S_IDLE,8'h03,0,0);
        add(1,0,0,2'b10,1,S_IDLE,8'h13,0,0);
        for (int k = 4; k <= 10; k++) add(1,0,0,2'b01,1,S_IDLE,8'h10 + 8'(k % 10),0,0);
        add(1,0,0,2'b11,1,S_IDLE,8'h21,0,0);
        add(1,0,1,2'b01,1,S_IDLE,8'h00,0,0);
        add(1,1,0,2'b00,1,S_IDLE,8'h00,0,0);
        // Borrow 10 -> 09, pause for 20 cycles, resume from frozen tick
        add(1,0,0,2'b10,1,S_IDLE,8'h10,0,0);
        add(1,1,0,2'b00,1,S_RUN,8'h10,0,0);
        add(1,0,0,2'b00,3,S_RUN,8'h10,0,0);
        add(1,0,0,2'b00,1,S_RUN,8'h09,0,0);
        add(1,0,0,2'b00,1,S_RUN,8'h09,0,0);
        add(1,1,0,2'b00,1,S_PAUSE,8'h09,0,0);
        add(1,0,0,2'b00,20,S_PAUSE,8'h09,0,0);
        add(1,1,0,2'b00,1,S_RUN,8'h09,0,0);
        add(1,0,0,2'b00,2,S_RUN,8'h09,0,0);
        add(1,0,0,2'b00,1,S_RUN,8'h08,0,0);
        add(1,1,0,2'b00,1,S_PAUSE,8'h08,0,0);
        add(1,0,1,2'b00,1,S_IDLE,8'h10,0,0);
        add(1,1,0,2'b00,1,S_RUN,8'h10,0,0);
        add(1,1,1,2'b00,1,S_IDLE,8'h10,0,0);
        // Full countdown 02 -> alarm -> timed return
        add(1,0,1,2'b00,1,S_IDLE,8'h00,0,0);
        add(1,0,0,2'b01,1,S_IDLE,8'h01,0,0);
        add(1,0,0,2'b01,1,S_IDLE,8'h02,0,0);
        add(1,1,0,2'b00,1,S_RUN,8'h02,0,0);
        add(1,0,0,2'b00,2,S_RUN,8'h02,0,0);
        add(1,0,0,2'b10,1,S_RUN,8'h02,0,0);
        add(1,0,0,2'b00,1,S_RUN,8'h01,0,0);
        add(1,0,0,2'b00,3,S_RUN,8'h01,0,0);
        add(1,0,0,2'b00,1,S_ALARM,8'h00,1,1);
        add(1,0,0,2'b00,7,S_ALARM,8'h00,1,0);
        add(1,0,0,2'b00,1,S_IDLE,8'h02,0,0);
        // Alarm aborted by key_start, inc ignored in alarm
        add(1,1,0,2'b00,1,S_RUN,8'h02,0,0);
        add(1,0,0,2'b00,3,S_RUN,8'h02,0,0);
        add(1,0,0,2'b00,1,S_RUN,8'h01,0,0);
        add(1,0,0,2'b00,3,S_RUN,8'h01,0,0);
        add(1,0,0,2'b00,1,S_ALARM,8'h00,1,1);
        add(1,0,0,2'b01,1,S_ALARM,8'h00,1,0);
        add(1,1,0,2'b00,1,S_IDLE,8'h02,0,0);
        // en=0 overrides start in RUN, preset lost
        add(1,1,0,2'b00,1,S_RUN,8'h02,0,0);
        add(1,0,0,2'b00,1,S_RUN,8'h02,0,0);
        add(0,1,0,2'b00,1,S_OFF,8'h00,0,0);
        add(1,0,0,2'b00,1,S_IDLE,8'h00,0,0);
        add(1,1,0,2'b00,1,S_IDLE,8'h00,0,0);

        #12;
        check("reset", S_OFF, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        foreach (vq[n]) begin
            for (int r = 0; r < vq[n].reps; r++) begin
                drive(vq[n].en, vq[n].start, vq[n].clr, vq[n].inc);
                check($sformatf("vec%0d.%0d", n, r), vq[n].exp_state, vq[n].exp_bcd,
                      vq[n].exp_beep, vq[n].exp_done);
            end
        end

        // Asynchronous reset in the middle of ALARM
        drive(1'b1, 1'b0, 1'b0, 2'b01);
        drive(1'b1, 1'b0, 1'b0, 2'b01);
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        begin
            int cyc;
            cyc = 0;
            while (state !== S_ALARM && cyc < 20) begin
                drive(1'b1, 1'b0, 1'b0, 2'b00);
                cyc++;
            end
            tests_run++;
            if (state !== S_ALARM) begin
                tests_failed++;
                $display("FAIL alarm_wait: got state=%0d after %0d cycles, expected state=%0d", state, cyc, S_ALARM);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        check("alarm_mid", S_ALARM, 8'h00, 1'b1, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst", S_OFF, 8'h00, 1'b0, 1'b0);
        #2;
        nrst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        check("post_rst_idle", S_IDLE, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'b00);
        check("post_rst_clr", S_IDLE, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits (legal range 1..4).
REQ-002 Parameter TICK_DIV, default 1000, clk cycles per one-second tick (legal range >=2).
REQ-003 Parameter BEEP_SEC, default 3, alarm duration in ticks (legal range >=1).
REQ-004 clk  input  1  system clock (1 kHz in product); all state changes on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  power switch level; 0 forces OFF.
REQ-007 key_start  input  1  debounced single-cycle pulse: start / pause / resume.
REQ-008 key_clr  input  1  debounced single-cycle pulse: clear / abort.
REQ-009 key_inc  input  DIGITS  debounced single-cycle pulses; bit i increments digit i (bit 0 = units).
REQ-010 bcd  output  4*DIGITS  current value, digit i in bits [4i+3:4i].
REQ-011 state  output  3  OFF=0, IDLE=1, RUN=2, PAUSE=3, ALARM=4.
REQ-012 beep  output  1  buzzer drive, high during ALARM.
REQ-013 done  output  1  one-cycle pulse on the cycle ALARM is entered.

Function
REQ-014 All outputs registered; key effects visible one cycle after the pulse.
REQ-015 OFF: bcd=0, preset=0, tick counter=0, beep=0; en=1 -> IDLE next cycle.
REQ-016 en=0 in any state -> OFF next cycle, overriding all keys.
REQ-017 IDLE: key_inc[i] -> digit i = (digit i + 1) mod 10, no carry into digit i+1; several bits in one cycle all apply.
REQ-018 IDLE: key_clr -> bcd=0 and preset=0.
REQ-019 IDLE: key_start with bcd != 0 -> copy bcd into preset, clear tick counter, go RUN; key_start with bcd == 0 is ignored.
REQ-020 RUN: tick counter counts 0..TICK_DIV-1 and wraps; on the wrap cycle bcd decrements by 1 with BCD borrow across all digits (e.g. 10 -> 09).
REQ-021 RUN: decrement that yields bcd == 0 -> ALARM on the same edge, done=1 for that cycle, tick counter cleared.
REQ-022 RUN: key_start -> PAUSE, tick counter and bcd frozen; decrement on the same cycle is suppressed.
REQ-023 PAUSE: key_start -> RUN resuming from the frozen tick count; key_clr -> IDLE with bcd reloaded from preset.
REQ-024 RUN: key_clr -> IDLE with bcd reloaded from preset.
REQ-025 RUN, PAUSE, ALARM: key_inc ignored.
REQ-026 ALARM: beep=1; after BEEP_SEC*TICK_DIV cycles -> IDLE, beep=0, bcd reloaded from preset.
REQ-027 ALARM: key_start or key_clr -> IDLE immediately with bcd reloaded from preset, beep=0 next cycle.
REQ-028 Same-cycle priority: en=0 > key_clr > key_start > key_inc.
REQ-029 State encodings 5..7 unreachable; if entered, next state IDLE with bcd=0.

Reset
REQ-030 nrst low asynchronously forces state=OFF, bcd=0, preset=0, tick and beep counters=0, beep=0, done=0.
REQ-031 Reset asserted mid-RUN or mid-ALARM discards preset; after release, block enters IDLE one cycle after en sampled high.

Verification (DIGITS=2, TICK_DIV=4, BEEP_SEC=2)
REQ-032 Reset, en=1, key_inc[0] x3, key_inc[1] x1 -> state=IDLE, bcd=0x13; key_inc[0] x7 more -> bcd=0x10 (no carry).
REQ-033 bcd=0x02, key_start -> RUN; bcd=0x01 after 4 cycles, 0x00 after 8 with done pulse, state=ALARM, beep=1 for 8 cycles, then IDLE, bcd=0x02.
REQ-034 bcd=0x10 in RUN -> next decrement gives 0x09; key_start -> PAUSE, bcd stable 20 cycles; key_start -> RUN resumes with remaining tick count.
REQ-035 bcd=0x00, key_start -> stays IDLE; key_clr and key_start in same RUN cycle -> IDLE, bcd=preset.
REQ-036 en dropped in RUN -> OFF, bcd=0 next cycle; nrst pulsed in ALARM -> beep=0 immediately, state=OFF.
